// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM encoding, latency bounds and the error check.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  // Misaligned or beyond the last word; no aliasing of high bits.
  function automatic logic addr_err(
    input logic [63:0] addr,
    input logic [63:0] depth
  );
    return (addr[1:0] != 2'b00) ||
           ((addr >> 2) >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W word storage, synchronous write and registered read.
// Ports: clk, we, re, idx, wdata in; rdata out. No reset on contents.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder on the MEM-stage load/store port.
// Ports: clk_i, rst_i (async low), req_* handshake in, resp_*, stall_o out.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [DATA_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              stall_o
);

  localparam int AW = $clog2(DEPTH);

  // Saturate so the counter width always covers the wait span.
  localparam int LAT =
    (LATENCY < LAT_MIN) ? LAT_MIN :
    (LATENCY > LAT_MAX) ? LAT_MAX :
    LATENCY;

  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              write_q;
  logic              err_q;
  logic [AW-1:0]     idx_q;
  logic [DATA_W-1:0] wdata_q;

  logic              resp_valid_q;
  logic              resp_err_q;
  logic              load_ok_q;

  logic              req_err;
  logic              access;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] arr_rdata;

  assign req_err = addr_err(64'(req_addr_i),
                            64'(DEPTH));

  // The one edge where the RAM is touched: last WAIT cycle.
  assign access = (state == ST_WAIT) &&
                  (cnt == '0);
  assign mem_we = access & write_q & ~err_q;
  assign mem_re = access & ~write_q & ~err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      write_q      <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_ok_q    <= 1'b0;
    end else begin
      resp_valid_q <= access;
      resp_err_q   <= access & err_q;
      load_ok_q    <= mem_re;
      unique case (state)
        ST_IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            err_q   <= req_err;
            idx_q   <= req_addr_i[2 +: AW];
            wdata_q <= req_wdata_i;
            cnt     <= CNT_INIT;
            state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk    (clk_i),
    .we     (mem_we),
    .re     (mem_re),
    .idx    (idx_q),
    .wdata  (wdata_q),
    .rdata  (arr_rdata)
  );

  assign req_ready_o  = (state == ST_IDLE);
  assign stall_o      = (state == ST_WAIT) |
                        ((state == ST_IDLE) & req_valid_i);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  // Stores and errors return zero; array register is unreset.
  assign resp_rdata_o = load_ok_q ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder.
// Stimulus pushes expected responses; a negedge monitor checks them.
module tb_dmem_responder;

  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic          req_write_i = 1'b0;
  logic [DW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          resp_valid_o;
  logic [DW-1:0] resp_rdata_o;
  logic          resp_err_o;
  logic          stall_o;

  dmem_responder #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_write_i  (req_write_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .stall_o      (stall_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          acc;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [DEPTH];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, handshake/stall shape, responses.
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("rst_valid", 32'(resp_valid_o), 0);
      chk("rst_rdata", resp_rdata_o, 0);
      chk("rst_err", 32'(resp_err_o), 0);
      chk("rst_ready", 32'(req_ready_o), 1);
      chk("rst_stall", 32'(stall_o), 32'(req_valid_i));
    end else if (sb.size() == 0) begin
      chk("idle_ready", 32'(req_ready_o), 1);
      chk("idle_stall", 32'(stall_o), 32'(req_valid_i));
      chk("idle_valid", 32'(resp_valid_o), 0);
      chk("idle_rdata", resp_rdata_o, 0);
      chk("idle_err", 32'(resp_err_o), 0);
    end else if (cyc == sb[0].acc + LAT + 1) begin
      exp_t e;
      e = sb.pop_front();
      chk("resp_ready", 32'(req_ready_o), 0);
      chk("resp_stall", 32'(stall_o), 0);
      chk("resp_valid", 32'(resp_valid_o), 1);
      chk("resp_rdata", resp_rdata_o, e.data);
      chk("resp_err", 32'(resp_err_o), 32'(e.err));
    end else begin
      chk("busy_ready", 32'(req_ready_o), 0);
      chk("busy_stall", 32'(stall_o), 1);
      chk("busy_valid", 32'(resp_valid_o), 0);
      chk("busy_rdata", resp_rdata_o, 0);
      chk("busy_err", 32'(resp_err_o), 0);
    end
  end

  // Present a request, wait for accept, push the expectation.
  task automatic issue(input bit w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input bit commit,
                       input bit keep);
    int  n;
    bit  e;
    exp_t x;
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (req_ready_o) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", 32'(req_ready_o), 1);
        req_valid_i = 1'b0;
        return;
      end
    end
    e = (a % 4 != 0) || ((a / 4) >= DEPTH);
    x.acc = cyc;
    x.err = e;
    x.data = (e || w) ? 32'h0 : model[a / 4];
    if (w && !e && commit) model[a / 4] = d;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (!keep) req_valid_i = 1'b0;
    req_write_i = 1'($urandom);
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
  endtask

  initial begin
    logic [31:0] a;
    int k;
    int gap;
    repeat (2) @(posedge clk);
    #1 req_valid_i = 1'b1;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < DEPTH; i++)
      issue(1, 32'(i * 4), $urandom, 1, 0);

    issue(1, 32'h10, 32'hDEADBEEF, 1, 0);
    issue(0, 32'h10, 32'h0, 1, 0);
    issue(0, 32'h13, 32'h0, 1, 0);
    issue(1, 32'h22, 32'h12345678, 1, 0);
    issue(0, 32'h20, 32'h0, 1, 0);
    issue(1, 32'h400, 32'hCAFEF00D, 1, 0);
    issue(0, 32'h0, 32'h0, 1, 0);
    issue(0, 32'h4, 32'h0, 1, 1);
    issue(0, 32'h8, 32'h0, 1, 1);
    issue(0, 32'hC, 32'h0, 1, 0);

    // Store dropped by reset two cycles after accept.
    issue(1, 32'h8, 32'h55, 0, 0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_addr_i  = 32'h8;
    @(posedge clk);
    #1 rst_i = 1'b1;
    issue(0, 32'h8, 32'h0, 1, 0);

    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      if (k < 7)
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (k == 7)
        a = (32'($urandom_range(0, DEPTH - 1)) << 2)
            | 32'($urandom_range(1, 3));
      else if (k == 8)
        a = 32'($urandom_range(DEPTH, 1 << 20)) << 2;
      else
        a = $urandom;
      gap = $urandom_range(0, 2);
      issue(1'($urandom), a, $urandom, 1, gap == 0);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (LAT + 4) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
